pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Pipeline sequencer between the opcode decoder and the 5-stage datapath. Tracks
//  ID->EX->MEM occupancy in a private scoreboard, issues load-use stalls, branch and
//  jump flushes, and freezes the whole pipe while data memory is not ready.
//  Drives every stage-register write enable and bubble control. Sits beside the
//  decoder in ID.
// PARAMETERS
//  FWD_EN       1   1: forwarding present, stall only on load-use; 0: stall on any RAW vs EX/MEM
//  MEM_TIMEOUT  16  max MEM_WAIT cycles before mem_err_o sets (>=1)
//  CNT_W        16  width of performance counters
// PORTS
//  clk_i          in   1      clock
//  rst_i          in   1      synchronous reset, active-high
//  id_rs_i        in   5      rs of instruction in ID
//  id_rt_i        in   5      rt of instruction in ID
//  id_use_rt_i    in   1      ID instruction reads rt (R-type, beq/bne, sw)
//  id_rd_i        in   5      ID write register after RegDst mux
//  id_regwrite_i  in   1      decoder RegWrite
//  id_memread_i   in   1      decoder MemRead
//  id_memwrite_i  in   1      decoder MemWrite
//  id_jump_n_i    in   1      decoder Jump, active-low (0 = jump)
//  ex_br_taken_i  in   1      branch in EX resolved taken
//  dmem_ready_i   in   1      data memory done for the MEM-stage access
//  pc_write_o     out  1      PC enable
//  ifid_write_o   out  1      IF/ID enable
//  ifid_flush_o   out  1      IF/ID loads NOP
//  idex_bubble_o  out  1      ID/EX loads zero controls
//  pipe_freeze_o  out  1      hold ID/EX, EX/MEM, MEM/WB
//  mem_err_o      out  1      sticky memory timeout
//  stall_cnt_o    out  CNT_W  saturating count of stall+freeze cycles
//  flush_cnt_o    out  CNT_W  saturating count of flush events
// BEHAVIOUR
//  Scoreboard: ex_q / mem_q = {valid, regwrite, memread, memwrite, rd}; id_v flags IF/ID valid.
//  Control outputs are combinational from state, scoreboard, inputs (same-cycle effect).
//  FSM RUN / MEM_WAIT. RUN->MEM_WAIT when mem_q.valid & (memread|memwrite) & !dmem_ready_i;
//   MEM_WAIT->RUN on dmem_ready_i. In MEM_WAIT: freeze=1, pc_write=ifid_write=0,
//   scoreboard holds. Wait counter increments per MEM_WAIT cycle; reaching MEM_TIMEOUT sets
//   mem_err_o (sticky until reset); FSM stays in MEM_WAIT.
//  RAW hit: ex_q.valid & regwrite & rd!=0 & (rd==id_rs_i | (id_use_rt_i & rd==id_rt_i));
//   same for mem_q. Load-use = EX hit & ex_q.memread. Stall = id_v & (load-use |
//   (!FWD_EN & (EX hit | MEM hit))).
//  Priority per cycle: reset > freeze > ex_br_taken_i > jump > stall.
//   branch taken: ifid_flush=1, idex_bubble=1, pc_write=1; stall suppressed; flush_cnt+1.
//   jump (id_v & !id_jump_n_i): ifid_flush=1, pc_write=1; flush_cnt+1.
//   stall: pc_write=0, ifid_write=0, idex_bubble=1; stall_cnt+1.
//   else pc_write=ifid_write=1, others 0.
//  Branch during freeze: no flush issued; ex_br_taken_i persists, flush applied the cycle
//   freeze drops.
//  Scoreboard advance when not frozen: mem_q<=ex_q; ex_q<=(bubble|!id_v)?0:ID fields;
//   id_v<=!ifid_flush.
//  Counters saturate at all-ones, no wrap; stall_cnt counts freeze cycles too.
//  rd==0 never causes a hazard. Reset mid-MEM_WAIT: back to RUN immediately.
//  Reset values: state RUN, ex_q=mem_q=0, id_v=0, wait cnt 0, mem_err_o=0, counters 0;
//   outputs pc_write_o=1, ifid_write_o=1, ifid_flush_o=0, idex_bubble_o=0, pipe_freeze_o=0.
// TESTING
//  lw $2 then add $3,$2,$4 -> one cycle pc_write=0, idex_bubble=1; stall_cnt=1; add issues next.
//  FWD_EN=0, add $2 then sub $5,$2,$1 -> 2 stall cycles; FWD_EN=1 -> 0 stalls.
//  lw with dmem_ready_i low 3 cycles -> pipe_freeze=1 for exactly 3 cycles, then RUN.
//  ex_br_taken_i with load-use in ID same cycle -> ifid_flush=idex_bubble=1, pc_write=1, no stall.
//  dmem_ready_i held low 20 cycles (MEM_TIMEOUT=16) -> mem_err_o=1 after 16th; rst_i clears all.
//  lw writing $0 then use of $0 -> no stall; stall_cnt stays 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Pipeline sequencer for a 5-stage datapath. Keeps a private scoreboard of the
//   instructions in EX and MEM, detects RAW hazards against the instruction in ID,
//   and drives the stage-register enables: load-use stalls, branch/jump flushes,
//   and a full-pipe freeze while data memory has not finished the MEM access.
//
//   Handshake with data memory: a MEM-stage access (load or store) completes in
//   the cycle dmem_ready_i is high; while it is low the whole pipe is frozen and
//   the access is presented again next cycle.
//
// Ports
//   clk_i, rst_i               clock, synchronous active-high reset
//   id_rs_i, id_rt_i           source registers of the instruction in ID
//   id_use_rt_i                ID instruction actually reads rt
//   id_rd_i                    ID destination register (after RegDst mux)
//   id_regwrite_i/memread_i/memwrite_i   decoder controls for the ID instruction
//   id_jump_n_i                ID instruction is a jump (active-low)
//   ex_br_taken_i              branch in EX resolved taken
//   dmem_ready_i               data memory completed the MEM-stage access
//   pc_write_o, ifid_write_o   PC and IF/ID enables
//   ifid_flush_o               IF/ID loads a NOP
//   idex_bubble_o              ID/EX loads zero controls
//   pipe_freeze_o              hold ID/EX, EX/MEM, MEM/WB
//   mem_err_o                  sticky memory timeout
//   stall_cnt_o, flush_cnt_o   saturating performance counters
module pipe_hazard_ctrl #(
  parameter bit          FWD_EN      = 1'b1,
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       id_rs_i,
  input  logic [4:0]       id_rt_i,
  input  logic             id_use_rt_i,
  input  logic [4:0]       id_rd_i,
  input  logic             id_regwrite_i,
  input  logic             id_memread_i,
  input  logic             id_memwrite_i,
  input  logic             id_jump_n_i,
  input  logic             ex_br_taken_i,
  input  logic             dmem_ready_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic             pipe_freeze_o,
  output logic             mem_err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int unsigned WCW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

  typedef struct packed {
    logic       valid;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic [4:0] rd;
  } sb_t;

  state_t           state_q, state_d;
  sb_t              ex_q, ex_d, mem_q, mem_d, id_fields;
  logic             id_v_q, id_v_d;
  logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
  logic             mem_err_q, mem_err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  logic ex_hit, mem_hit, load_use, stall_req, jump_req, freeze;
  logic stall_taken, flush_taken;

  assign id_fields = '{valid: 1'b1, regwrite: id_regwrite_i, memread: id_memread_i,
                       memwrite: id_memwrite_i, rd: id_rd_i};

  // Hazard detection against the instructions currently in EX and MEM.
  always_comb begin
    ex_hit   = ex_q.valid & ex_q.regwrite & (ex_q.rd != 5'd0) &
               ((ex_q.rd == id_rs_i) | (id_use_rt_i & (ex_q.rd == id_rt_i)));
    mem_hit  = mem_q.valid & mem_q.regwrite & (mem_q.rd != 5'd0) &
               ((mem_q.rd == id_rs_i) | (id_use_rt_i & (mem_q.rd == id_rt_i)));
    load_use = ex_hit & ex_q.memread;
    stall_req = id_v_q & (load_use | (!FWD_EN & (ex_hit | mem_hit)));
    jump_req  = id_v_q & !id_jump_n_i;
    // The freeze is raised in the same cycle the pending access sees !ready, so the
    // access never slips out of MEM before memory has accepted it. In MEM_WAIT the
    // scoreboard is held, so mem_q still describes the waiting access.
    freeze = ((state_q == MEM_WAIT) |
              (mem_q.valid & (mem_q.memread | mem_q.memwrite))) & !dmem_ready_i;
  end

  // FSM next state and control outputs, priority freeze > branch > jump > stall.
  always_comb begin
    state_d       = state_q;
    pc_write_o    = 1'b1;
    ifid_write_o  = 1'b1;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;
    pipe_freeze_o = 1'b0;
    stall_taken   = 1'b0;
    flush_taken   = 1'b0;

    case (state_q)
      RUN:      if (freeze) state_d = MEM_WAIT;
      MEM_WAIT: if (dmem_ready_i) state_d = RUN;
      default:  state_d = RUN;
    endcase

    if (freeze) begin
      pipe_freeze_o = 1'b1;
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      stall_taken   = 1'b1;
    end else if (ex_br_taken_i) begin
      // A taken branch discards the ID instruction, so any stall it asked for is moot.
      ifid_flush_o  = 1'b1;
      idex_bubble_o = 1'b1;
      flush_taken   = 1'b1;
    end else if (jump_req) begin
      ifid_flush_o  = 1'b1;
      flush_taken   = 1'b1;
    end else if (stall_req) begin
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      idex_bubble_o = 1'b1;
      stall_taken   = 1'b1;
    end
  end

  // Scoreboard, wait counter, error flag and performance counters.
  always_comb begin
    ex_d        = ex_q;
    mem_d       = mem_q;
    id_v_d      = id_v_q;
    wait_cnt_d  = '0;
    mem_err_d   = mem_err_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;

    if (!freeze) begin
      mem_d  = ex_q;
      ex_d   = (idex_bubble_o | !id_v_q) ? sb_t'('0) : id_fields;
      id_v_d = !ifid_flush_o;
    end else begin
      if (wait_cnt_q != WCW'(MEM_TIMEOUT)) wait_cnt_d = wait_cnt_q + 1'b1;
      else                                 wait_cnt_d = wait_cnt_q;
      if (wait_cnt_q == WCW'(MEM_TIMEOUT - 1)) mem_err_d = 1'b1;
    end

    if (stall_taken && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    if (flush_taken && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= RUN;
      ex_q        <= '0;
      mem_q       <= '0;
      id_v_q      <= 1'b0;
      wait_cnt_q  <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      id_v_q      <= id_v_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign mem_err_o   = mem_err_q;
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: three instances share all inputs -- forwarding
// (dut_f), no forwarding (dut_n), and a small-counter / short-timeout copy (dut_s).
// Control vectors are packed {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze}.
module tb_pipe_hazard_ctrl;

  localparam logic [4:0] C_RUN   = 5'b11000;
  localparam logic [4:0] C_STALL = 5'b00010;
  localparam logic [4:0] C_FRZ   = 5'b00001;
  localparam logic [4:0] C_BR    = 5'b11110;
  localparam logic [4:0] C_JMP   = 5'b11100;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       id_use_rt, id_regwrite, id_memread, id_memwrite, id_jump_n;
  logic       ex_br_taken, dmem_ready;

  wire [4:0]  ctl_f, ctl_n, ctl_s;
  wire        err_f, err_n, err_s;
  wire [15:0] stall_f, flush_f, stall_n, flush_n;
  wire [2:0]  stall_s, flush_s;

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [9:0] exp_q[$];

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.FWD_EN(1'b1), .MEM_TIMEOUT(16), .CNT_W(16)) dut_f (
    .clk_i(clk), .rst_i(rst), .id_rs_i(id_rs), .id_rt_i(id_rt), .id_use_rt_i(id_use_rt),
    .id_rd_i(id_rd), .id_regwrite_i(id_regwrite), .id_memread_i(id_memread),
    .id_memwrite_i(id_memwrite), .id_jump_n_i(id_jump_n), .ex_br_taken_i(ex_br_taken),
    .dmem_ready_i(dmem_ready), .pc_write_o(ctl_f[4]), .ifid_write_o(ctl_f[3]),
    .ifid_flush_o(ctl_f[2]), .idex_bubble_o(ctl_f[1]), .pipe_freeze_o(ctl_f[0]),
    .mem_err_o(err_f), .stall_cnt_o(stall_f), .flush_cnt_o(flush_f));

  pipe_hazard_ctrl #(.FWD_EN(1'b0), .MEM_TIMEOUT(16), .CNT_W(16)) dut_n (
    .clk_i(clk), .rst_i(rst), .id_rs_i(id_rs), .id_rt_i(id_rt), .id_use_rt_i(id_use_rt),
    .id_rd_i(id_rd), .id_regwrite_i(id_regwrite), .id_memread_i(id_memread),
    .id_memwrite_i(id_memwrite), .id_jump_n_i(id_jump_n), .ex_br_taken_i(ex_br_taken),
    .dmem_ready_i(dmem_ready), .pc_write_o(ctl_n[4]), .ifid_write_o(ctl_n[3]),
    .ifid_flush_o(ctl_n[2]), .idex_bubble_o(ctl_n[1]), .pipe_freeze_o(ctl_n[0]),
    .mem_err_o(err_n), .stall_cnt_o(stall_n), .flush_cnt_o(flush_n));

  pipe_hazard_ctrl #(.FWD_EN(1'b1), .MEM_TIMEOUT(4), .CNT_W(3)) dut_s (
    .clk_i(clk), .rst_i(rst), .id_rs_i(id_rs), .id_rt_i(id_rt), .id_use_rt_i(id_use_rt),
    .id_rd_i(id_rd), .id_regwrite_i(id_regwrite), .id_memread_i(id_memread),
    .id_memwrite_i(id_memwrite), .id_jump_n_i(id_jump_n), .ex_br_taken_i(ex_br_taken),
    .dmem_ready_i(dmem_ready), .pc_write_o(ctl_s[4]), .ifid_write_o(ctl_s[3]),
    .ifid_flush_o(ctl_s[2]), .idex_bubble_o(ctl_s[1]), .pipe_freeze_o(ctl_s[0]),
    .mem_err_o(err_s), .stall_cnt_o(stall_s), .flush_cnt_o(flush_s));

  // ---------------- driver tasks ----------------
  task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic use_rt,
                        input logic [4:0] rd, input logic rw, input logic mr,
                        input logic mw, input logic jn);
    id_rs = rs; id_rt = rt; id_use_rt = use_rt; id_rd = rd;
    id_regwrite = rw; id_memread = mr; id_memwrite = mw; id_jump_n = jn;
  endtask

  task automatic set_nop();
    set_id(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // One cycle: expected controls go into the scoreboard as the stimulus is applied
  // and are checked against the DUTs mid-cycle, away from the clock edge.
  task automatic drive_cycle(input logic [4:0] ef, input logic [4:0] en);
    logic [9:0] e;
    exp_q.push_back({ef, en});
    @(negedge clk);
    e = exp_q.pop_front();
    vec_cnt++;
    if (ctl_f !== e[9:5]) begin
      err_cnt++;
      $display("FAIL ctl_fwd t=%0t got %b want %b", $time, ctl_f, e[9:5]);
    end
    vec_cnt++;
    if (ctl_s !== e[9:5]) begin
      err_cnt++;
      $display("FAIL ctl_small t=%0t got %b want %b", $time, ctl_s, e[9:5]);
    end
    vec_cnt++;
    if (ctl_n !== e[4:0]) begin
      err_cnt++;
      $display("FAIL ctl_nofwd t=%0t got %b want %b", $time, ctl_n, e[4:0]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_nop();
    ex_br_taken = 1'b0;
    dmem_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    vec_cnt++;
    if (ctl_f !== C_RUN || ctl_n !== C_RUN) begin
      err_cnt++;
      $display("FAIL reset_ctl got %b/%b want %b", ctl_f, ctl_n, C_RUN);
    end
    vec_cnt++;
    if (stall_f !== 16'd0 || flush_f !== 16'd0 || err_f !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_state got stall=%0d flush=%0d err=%b want 0/0/0",
               stall_f, flush_f, err_f);
    end
    drive_cycle(C_RUN, C_RUN);
  endtask

  task automatic test_load_use();
    do_reset(); drive_cycle(C_RUN, C_RUN);
    set_id(5'd1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0, 1'b1);   // lw $2,0($1)
    drive_cycle(C_RUN, C_RUN);
    set_id(5'd2, 5'd4, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1);   // add $3,$2,$4
    drive_cycle(C_STALL, C_STALL);
    drive_cycle(C_RUN, C_STALL);                              // nofwd: lw now in MEM
    drive_cycle(C_RUN, C_RUN);
    vec_cnt++;
    if (stall_f !== 16'd1) begin
      err_cnt++; $display("FAIL lu_stall_fwd got %0d want 1", stall_f);
    end
    vec_cnt++;
    if (stall_n !== 16'd2) begin
      err_cnt++; $display("FAIL lu_stall_nofwd got %0d want 2", stall_n);
    end
  endtask

  task automatic test_raw_alu();
    do_reset(); drive_cycle(C_RUN, C_RUN);
    set_id(5'd3, 5'd4, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b1);   // add $2,$3,$4
    drive_cycle(C_RUN, C_RUN);
    set_id(5'd2, 5'd1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1);   // sub $5,$2,$1
    drive_cycle(C_RUN, C_STALL);
    drive_cycle(C_RUN, C_STALL);
    drive_cycle(C_RUN, C_RUN);
    vec_cnt++;
    if (stall_f !== 16'd0) begin
      err_cnt++; $display("FAIL raw_stall_fwd got %0d want 0", stall_f);
    end
    vec_cnt++;
    if (stall_n !== 16'd2) begin
      err_cnt++; $display("FAIL raw_stall_nofwd got %0d want 2", stall_n);
    end
  endtask

  task automatic test_mem_freeze();
    do_reset(); drive_cycle(C_RUN, C_RUN);
    set_id(5'd1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0, 1'b1);   // lw $2
    drive_cycle(C_RUN, C_RUN);
    set_nop();
    drive_cycle(C_RUN, C_RUN);
    dmem_ready = 1'b0;
    drive_cycle(C_FRZ, C_FRZ);
    drive_cycle(C_FRZ, C_FRZ);
    ex_br_taken = 1'b1;                                       // branch held off by freeze
    drive_cycle(C_FRZ, C_FRZ);
    dmem_ready = 1'b1;
    drive_cycle(C_BR, C_BR);
    ex_br_taken = 1'b0;
    drive_cycle(C_RUN, C_RUN);
    vec_cnt++;
    if (stall_f !== 16'd3 || flush_f !== 16'd1) begin
      err_cnt++; $display("FAIL frz_counts got stall=%0d flush=%0d want 3/1", stall_f, flush_f);
    end
    vec_cnt++;
    if (err_f !== 1'b0) begin
      err_cnt++; $display("FAIL frz_err got %b want 0", err_f);
    end
  endtask

  task automatic test_branch_over_load_use();
    do_reset(); drive_cycle(C_RUN, C_RUN);
    set_id(5'd1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0, 1'b1);   // lw $2
    drive_cycle(C_RUN, C_RUN);
    set_id(5'd2, 5'd4, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1);   // add $3,$2,$4
    ex_br_taken = 1'b1;
    drive_cycle(C_BR, C_BR);
    ex_br_taken = 1'b0;
    drive_cycle(C_RUN, C_RUN);                                // flushed slot: no stall
    vec_cnt++;
    if (stall_f !== 16'd0 || flush_f !== 16'd1) begin
      err_cnt++; $display("FAIL br_counts got stall=%0d flush=%0d want 0/1", stall_f, flush_f);
    end
    vec_cnt++;
    if (stall_n !== 16'd0 || flush_s !== 3'd1) begin
      err_cnt++; $display("FAIL br_counts2 got stall_n=%0d flush_s=%0d want 0/1", stall_n, flush_s);
    end
  endtask

  task automatic test_jump();
    do_reset(); drive_cycle(C_RUN, C_RUN);
    set_id(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);   // j target
    drive_cycle(C_JMP, C_JMP);
    drive_cycle(C_RUN, C_RUN);                                // flushed copy ignored
    set_nop();
    drive_cycle(C_RUN, C_RUN);
    vec_cnt++;
    if (flush_f !== 16'd1) begin
      err_cnt++; $display("FAIL jmp_flush got %0d want 1", flush_f);
    end
  endtask

  task automatic test_reg_zero();
    do_reset(); drive_cycle(C_RUN, C_RUN);
    set_id(5'd1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1);   // lw $0
    drive_cycle(C_RUN, C_RUN);
    set_id(5'd0, 5'd0, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1);   // add $3,$0,$0
    drive_cycle(C_RUN, C_RUN);
    drive_cycle(C_RUN, C_RUN);
    vec_cnt++;
    if (stall_f !== 16'd0 || stall_n !== 16'd0) begin
      err_cnt++; $display("FAIL r0_stall got %0d/%0d want 0/0", stall_f, stall_n);
    end
  endtask

  task automatic test_timeout();
    do_reset(); drive_cycle(C_RUN, C_RUN);
    set_id(5'd1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0, 1'b1);   // lw $2
    drive_cycle(C_RUN, C_RUN);
    set_nop();
    drive_cycle(C_RUN, C_RUN);
    dmem_ready = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      drive_cycle(C_FRZ, C_FRZ);
      vec_cnt++;
      if (err_f !== (k >= 16)) begin
        err_cnt++; $display("FAIL tmo_err k=%0d got %b want %b", k, err_f, (k >= 16));
      end
    end
    vec_cnt++;
    if (err_s !== 1'b1 || stall_s !== 3'd7) begin
      err_cnt++; $display("FAIL tmo_small got err=%b stall=%0d want 1/7", err_s, stall_s);
    end
    vec_cnt++;
    if (stall_f !== 16'd20) begin
      err_cnt++; $display("FAIL tmo_stall got %0d want 20", stall_f);
    end
    // Reset while still waiting on memory.
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    vec_cnt++;
    if (ctl_f !== C_RUN || err_f !== 1'b0 || stall_f !== 16'd0) begin
      err_cnt++;
      $display("FAIL tmo_reset got ctl=%b err=%b stall=%0d want %b/0/0", ctl_f, err_f, stall_f, C_RUN);
    end
    drive_cycle(C_RUN, C_RUN);                                // ready still low, no access
    dmem_ready = 1'b1;
    drive_cycle(C_RUN, C_RUN);
  endtask

  task automatic test_random_nops();
    do_reset(); drive_cycle(C_RUN, C_RUN);
    for (int i = 0; i < 8; i++) begin
      // Non-writing instructions with random sources never hazard.
      set_id(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1'b1,
             5'($urandom_range(1, 31)), 1'b0, 1'b0, 1'b0, 1'b1);
      drive_cycle(C_RUN, C_RUN);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_raw_alu();
    test_mem_freeze();
    test_branch_over_load_use();
    test_jump();
    test_reg_zero();
    test_timeout();
    test_random_nops();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
